// File: rtl/round_scorer_if.sv
// Round-event bus between the game datapath and round_scorer.
// The streak_bonus signal exists only when ROUND_SCORER_STREAK_EN is defined.
interface round_scorer_if;
  logic       round_start;
  logic       load_p1;
  logic       matched;
  logic       unmatched;
  logic       time_out;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] miss_count;
  logic [3:0] round_count;
  logic       round_active;
  logic       round_done;
  logic       last_hit;
  logic       game_over;
`ifdef ROUND_SCORER_STREAK_EN
  logic       streak_bonus;
`endif

  // The datapath side drives round events and watches the score.
  modport master (
    output round_start,
    output load_p1,
    output matched,
    output unmatched,
    output time_out,
    input  score_ones,
    input  score_tens,
    input  miss_count,
    input  round_count,
    input  round_active,
    input  round_done,
    input  last_hit,
`ifdef ROUND_SCORER_STREAK_EN
    input  streak_bonus,
`endif
    input  game_over
  );

  modport slave (
    input  round_start,
    input  load_p1,
    input  matched,
    input  unmatched,
    input  time_out,
    output score_ones,
    output score_tens,
    output miss_count,
    output round_count,
    output round_active,
    output round_done,
    output last_hit,
`ifdef ROUND_SCORER_STREAK_EN
    output streak_bonus,
`endif
    output game_over
  );
endinterface

// File: rtl/round_scorer.sv
// Round scorer: turns datapath round events into a saturating BCD score, miss/round counts and game over.
// Build macro ROUND_SCORER_STREAK_EN adds a three-hit streak bonus and the streak_bonus output.
module round_scorer #(
  parameter int MAX_ROUNDS = 10,
  parameter int MAX_MISSES = 3,
  parameter int EVAL_DELAY = 2
) (
  input logic           clk,
  input logic           rst,
  round_scorer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT,
    SCORE,
    OVER
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] delay_cnt;
  logic [2:0] delay_cnt_nxt;
  logic       hit_q;
  logic       hit_nxt;
  logic [3:0] score_ones_q;
  logic [3:0] score_tens_q;
  logic [7:0] score_nxt;
  logic [3:0] miss_q;
  logic [3:0] miss_nxt;
  logic [3:0] rounds_q;
  logic [3:0] rounds_nxt;
  logic       last_hit_q;
  logic       last_hit_nxt;
  logic       done_q;
  logic       done_nxt;
  logic       active_q;
  logic       active_nxt;
  logic       over_q;
  logic       over_nxt;
`ifdef ROUND_SCORER_STREAK_EN
  logic [1:0] streak_q;
  logic [1:0] streak_nxt;
  logic       bonus_q;
  logic       bonus_nxt;
`endif

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    logic [7:0] res;
    if (bcd == 8'h99) begin
      res = bcd;
    end else if (bcd[3:0] == 4'd9) begin
      res = {bcd[7:4] + 4'd1, 4'd0};
    end else begin
      res = {bcd[7:4], bcd[3:0] + 4'd1};
    end
    return res;
  endfunction

  always_comb begin
    next_state    = state;
    delay_cnt_nxt = delay_cnt;
    hit_nxt       = hit_q;
    score_nxt     = {score_tens_q, score_ones_q};
    miss_nxt      = miss_q;
    rounds_nxt    = rounds_q;
    last_hit_nxt  = last_hit_q;
    done_nxt      = 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
    streak_nxt    = streak_q;
    bonus_nxt     = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (bus.round_start) begin
          next_state = ARMED;
        end
      end

      // A load in the same cycle as a timeout still counts as an answer.
      ARMED: begin
        if (bus.load_p1) begin
          next_state    = WAIT;
          delay_cnt_nxt = 3'(EVAL_DELAY - 1);
        end else if (bus.time_out) begin
          next_state = SCORE;
          hit_nxt    = 1'b0;
        end
      end

      WAIT: begin
        if (delay_cnt == 3'd0) begin
          next_state = SCORE;
          hit_nxt    = bus.matched & ~bus.unmatched;
        end else begin
          delay_cnt_nxt = delay_cnt - 3'd1;
        end
      end

      SCORE: begin
        done_nxt   = 1'b1;
        rounds_nxt = (rounds_q == 4'd15) ? rounds_q : rounds_q + 4'd1;
        if (hit_q) begin
          last_hit_nxt = 1'b1;
`ifdef ROUND_SCORER_STREAK_EN
          if (streak_q == 2'd2) begin
            score_nxt  = bcd_inc(bcd_inc({score_tens_q, score_ones_q}));
            streak_nxt = 2'd0;
            bonus_nxt  = 1'b1;
          end else begin
            score_nxt  = bcd_inc({score_tens_q, score_ones_q});
            streak_nxt = streak_q + 2'd1;
          end
`else
          score_nxt = bcd_inc({score_tens_q, score_ones_q});
`endif
        end else begin
          last_hit_nxt = 1'b0;
          miss_nxt     = (miss_q == 4'd15) ? miss_q : miss_q + 4'd1;
`ifdef ROUND_SCORER_STREAK_EN
          streak_nxt   = 2'd0;
`endif
        end
        if ((miss_nxt == 4'(MAX_MISSES)) || (rounds_nxt == 4'(MAX_ROUNDS))) begin
          next_state = OVER;
        end else begin
          next_state = IDLE;
        end
      end

      OVER: begin
        next_state = OVER;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    active_nxt = (next_state == ARMED) || (next_state == WAIT) || (next_state == SCORE);
    over_nxt   = (next_state == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      delay_cnt    <= 3'd0;
      hit_q        <= 1'b0;
      score_ones_q <= 4'd0;
      score_tens_q <= 4'd0;
      miss_q       <= 4'd0;
      rounds_q     <= 4'd0;
      last_hit_q   <= 1'b0;
      done_q       <= 1'b0;
      active_q     <= 1'b0;
      over_q       <= 1'b0;
`ifdef ROUND_SCORER_STREAK_EN
      streak_q     <= 2'd0;
      bonus_q      <= 1'b0;
`endif
    end else begin
      state        <= next_state;
      delay_cnt    <= delay_cnt_nxt;
      hit_q        <= hit_nxt;
      score_ones_q <= score_nxt[3:0];
      score_tens_q <= score_nxt[7:4];
      miss_q       <= miss_nxt;
      rounds_q     <= rounds_nxt;
      last_hit_q   <= last_hit_nxt;
      done_q       <= done_nxt;
      active_q     <= active_nxt;
      over_q       <= over_nxt;
`ifdef ROUND_SCORER_STREAK_EN
      streak_q     <= streak_nxt;
      bonus_q      <= bonus_nxt;
`endif
    end
  end

  assign bus.score_ones   = score_ones_q;
  assign bus.score_tens   = score_tens_q;
  assign bus.miss_count   = miss_q;
  assign bus.round_count  = rounds_q;
  assign bus.round_active = active_q;
  assign bus.round_done   = done_q;
  assign bus.last_hit     = last_hit_q;
  assign bus.game_over    = over_q;
`ifdef ROUND_SCORER_STREAK_EN
  assign bus.streak_bonus = bonus_q;
`endif

endmodule
